// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stage-control bus between the pipeline and pipe_ctrl
interface pipe_ctrl_if #(
   parameter int PC_W = 30
);
   logic            if_busy;
   logic            mem_busy;
   logic            ld_hazard;
   logic            mem_en;
   logic [PC_W-1:0] mem_pc;
   logic [2:0]      mem_exp;

   logic            if_stall, id_stall, ex_stall, mem_stall;
   logic            if_flush, id_flush, ex_flush, mem_flush;
   logic [PC_W-1:0] new_pc;

   modport master (
      input  if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_exp,
      output if_stall, id_stall, ex_stall, mem_stall,
      output if_flush, id_flush, ex_flush, mem_flush, new_pc
   );

   modport slave (
      output if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_exp,
      input  if_stall, id_stall, ex_stall, mem_stall,
      input  if_flush, id_flush, ex_flush, mem_flush, new_pc
   );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller with EPC and handler-mode state
// Optional performance counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int              PC_W       = 30,
   parameter logic [PC_W-1:0] EXC_VECTOR = 30'h0000_0010,
   parameter logic [PC_W-1:0] RESET_PC   = 30'h0
) (
   input  logic            clk,
   input  logic            reset,
   pipe_ctrl_if.master     bus,
   input  logic            irq,
   input  logic            int_en,
   output logic [PC_W-1:0] epc,
   output logic [2:0]      exp_code,
   output logic            in_handler,
   output logic            halted
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [15:0]     exc_cnt
`endif
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [2:0] EXP_NONE = 3'd0;
   localparam logic [2:0] EXP_IRQ  = 3'd1;
   localparam logic [2:0] EXP_PRIV = 3'd6;
   localparam logic [2:0] EXP_ERET = 3'd7;

   state_t     state, state_nxt;
   logic       can_acc, acc_eret, acc_fault, acc_irq, acc, double_fault;
   logic [2:0] fault_code;

   // Acceptance only on a valid, non-waiting MEM instruction while running.
   always_comb begin
      can_acc      = (state == RUN) && !bus.mem_busy && bus.mem_en;
      acc_eret     = can_acc && (bus.mem_exp == EXP_ERET) && in_handler;
      acc_fault    = can_acc && ((bus.mem_exp inside {[3'd2:3'd6]}) ||
                                 ((bus.mem_exp == EXP_ERET) && !in_handler));
      acc_irq      = can_acc && (bus.mem_exp == EXP_NONE) && irq && int_en && !in_handler;
      acc          = acc_eret || acc_fault || acc_irq;
      double_fault = acc_fault && in_handler;
      fault_code   = (bus.mem_exp == EXP_ERET) ? EXP_PRIV : bus.mem_exp;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if ((state == RUN) && double_fault) state_nxt = HALT;
   end

   always_comb begin
      bus.if_stall  = 1'b0;
      bus.id_stall  = 1'b0;
      bus.ex_stall  = 1'b0;
      bus.mem_stall = 1'b0;
      bus.if_flush  = 1'b0;
      bus.id_flush  = 1'b0;
      bus.ex_flush  = 1'b0;
      bus.mem_flush = 1'b0;
      bus.new_pc    = EXC_VECTOR;
      if (!reset || (state == HALT) || bus.mem_busy) begin
         bus.if_stall  = 1'b1;
         bus.id_stall  = 1'b1;
         bus.ex_stall  = 1'b1;
         bus.mem_stall = 1'b1;
         if (!reset) bus.new_pc = RESET_PC;
      end else if (acc) begin
         bus.if_flush  = 1'b1;
         bus.id_flush  = 1'b1;
         bus.ex_flush  = 1'b1;
         bus.mem_flush = 1'b1;
         if (acc_eret) bus.new_pc = epc;
      end else if (bus.ld_hazard || bus.if_busy) begin
         bus.if_stall = 1'b1;
         bus.id_stall = 1'b1;
         bus.id_flush = 1'b1;
      end
   end

   // A double fault leaves epc/exp_code describing the first fault.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         epc        <= '0;
         exp_code   <= EXP_NONE;
         in_handler <= 1'b0;
         halted     <= 1'b0;
      end else if (double_fault) begin
         halted     <= 1'b1;
      end else if (acc_fault) begin
         epc        <= bus.mem_pc;
         exp_code   <= fault_code;
         in_handler <= 1'b1;
      end else if (acc_irq) begin
         epc        <= bus.mem_pc;
         exp_code   <= EXP_IRQ;
         in_handler <= 1'b1;
      end else if (acc_eret) begin
         in_handler <= 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         exc_cnt   <= '0;
      end else begin
         if (bus.if_stall && (state != HALT)) stall_cnt <= stall_cnt + 32'd1;
         if (acc_fault || acc_irq)            exc_cnt   <= exc_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;
   localparam int PC_W = 30;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            irq = 1'b0;
   logic            int_en = 1'b0;
   logic [PC_W-1:0] epc;
   logic [2:0]      exp_code;
   logic            in_handler;
   logic            halted;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]     stall_cnt;
   logic [15:0]     exc_cnt;
   logic [31:0]     sc_snap;
   logic [15:0]     ec_snap;
`endif

   pipe_ctrl_if #(.PC_W(PC_W)) bus();

   pipe_ctrl #(.PC_W(PC_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.master),
      .irq        (irq),
      .int_en     (int_en),
      .epc        (epc),
      .exp_code   (exp_code),
      .in_handler (in_handler),
      .halted     (halted)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .exc_cnt    (exc_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string           tag;
      logic [3:0]      st;
      logic [3:0]      fl;
      logic            chk_pc;
      logic [PC_W-1:0] pc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;

   wire [3:0] st_v = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall};
   wire [3:0] fl_v = {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush};

   task automatic drive(input logic ib, input logic mb, input logic hz, input logic en,
                        input logic [PC_W-1:0] pc, input logic [2:0] ex);
      bus.if_busy   = ib;
      bus.mem_busy  = mb;
      bus.ld_hazard = hz;
      bus.mem_en    = en;
      bus.mem_pc    = pc;
      bus.mem_exp   = ex;
   endtask

   task automatic expect_ctl(input string tag, input logic [3:0] st, input logic [3:0] fl,
                             input logic chk_pc, input logic [PC_W-1:0] pc);
      exp_t x;
      x.tag = tag; x.st = st; x.fl = fl; x.chk_pc = chk_pc; x.pc = pc;
      sb.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 1, 30'h5, 3'd3);
      expect_ctl("reset_ctl", 4'b1111, 4'b0000, 1'b1, 30'h0);
      #1;
      e = sb.pop_front(); checks++;
      if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
         failures++;
         $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                  e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
      end
      tick();
      checks++;
      if ({epc, exp_code, in_handler, halted} !== {30'h0, 3'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_regs: epc=%h code=%0d inh=%b halt=%b, want 0", epc, exp_code, in_handler, halted);
      end
      drive(0, 0, 0, 0, 30'h0, 3'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      expect_ctl("post_reset_idle", 4'b0000, 4'b0000, 1'b0, 30'h0);
      #1;
      e = sb.pop_front(); checks++;
      if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
         failures++;
         $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                  e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
      end
      checks++;
      if (in_handler !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_inh: got %b want 0", in_handler);
      end
   endtask

   task automatic test_mem_busy();
`ifdef PIPE_CTRL_PERF_EN
      sc_snap = stall_cnt;
`endif
      for (int i = 0; i < 4; i++) begin
         drive(0, (i < 3), 0, 1, 30'h100, 3'd3);
         if (i < 3) expect_ctl($sformatf("busy_cyc%0d", i), 4'b1111, 4'b0000, 1'b0, 30'h0);
         else       expect_ctl("busy_accept", 4'b0000, 4'b1111, 1'b1, 30'h10);
         #1;
         e = sb.pop_front(); checks++;
         if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
            failures++;
            $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                     e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
         end
         tick();
         if (i == 2) begin
            checks++;
            if ({epc, in_handler} !== {30'h0, 1'b0}) begin
               failures++;
               $display("FAIL busy_no_accept: epc=%h inh=%b want 0/0", epc, in_handler);
            end
`ifdef PIPE_CTRL_PERF_EN
            checks++;
            if (stall_cnt !== sc_snap + 32'd3) begin
               failures++;
               $display("FAIL busy_stall_cnt: got %0d want %0d", stall_cnt, sc_snap + 32'd3);
            end
`endif
         end
      end
      checks++;
      if ({epc, exp_code, in_handler} !== {30'h100, 3'd3, 1'b1}) begin
         failures++;
         $display("FAIL busy_regs: epc=%h code=%0d inh=%b want 100/3/1", epc, exp_code, in_handler);
      end
      drive(0, 0, 0, 1, 30'h104, 3'd7);
      expect_ctl("busy_eret", 4'b0000, 4'b1111, 1'b1, 30'h100);
      #1;
      e = sb.pop_front(); checks++;
      if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
         failures++;
         $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                  e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
      end
      tick();
   endtask

   task automatic test_ld_hazard();
      // hazard, idle, if_busy, idle
      for (int i = 0; i < 4; i++) begin
         drive((i == 2), 0, (i == 0), 1, 30'h200, 3'd0);
         if (i == 0 || i == 2) expect_ctl($sformatf("hazard_%0d", i), 4'b1100, 4'b0100, 1'b0, 30'h0);
         else                  expect_ctl($sformatf("hazard_clear_%0d", i), 4'b0000, 4'b0000, 1'b0, 30'h0);
         #1;
         e = sb.pop_front(); checks++;
         if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
            failures++;
            $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                     e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
         end
         tick();
      end
   endtask

   task automatic test_irq();
      irq = 1'b1;
      int_en = 1'b0;
      drive(0, 0, 0, 1, 30'h40, 3'd0);
      expect_ctl("irq_masked", 4'b0000, 4'b0000, 1'b0, 30'h0);
      drive(0, 0, 0, 0, 30'h40, 3'd0);
      expect_ctl("irq_no_mem_en", 4'b0000, 4'b0000, 1'b0, 30'h0);
      expect_ctl("irq_accept", 4'b0000, 4'b1111, 1'b1, 30'h10);
      expect_ctl("irq_in_handler", 4'b0000, 4'b0000, 1'b0, 30'h0);
      expect_ctl("irq_eret", 4'b0000, 4'b1111, 1'b1, 30'h40);
      expect_ctl("irq_vs_fault", 4'b0000, 4'b1111, 1'b1, 30'h10);
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: begin int_en = 1'b0; drive(0, 0, 0, 1, 30'h40, 3'd0); end
            1: begin int_en = 1'b1; drive(0, 0, 0, 0, 30'h40, 3'd0); end
            2: drive(0, 0, 0, 1, 30'h40, 3'd0);
            3: drive(0, 0, 0, 1, 30'h44, 3'd0);
            4: begin irq = 1'b0; drive(0, 0, 0, 1, 30'h55, 3'd7); end
            default: begin irq = 1'b1; drive(0, 0, 0, 1, 30'h60, 3'd4); end
         endcase
         #1;
         e = sb.pop_front(); checks++;
         if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
            failures++;
            $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                     e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
         end
         tick();
         if (i == 2) begin
            checks++;
            if ({epc, exp_code, in_handler} !== {30'h40, 3'd1, 1'b1}) begin
               failures++;
               $display("FAIL irq_regs: epc=%h code=%0d inh=%b want 40/1/1", epc, exp_code, in_handler);
            end
         end else if (i == 4) begin
            checks++;
            if ({epc, exp_code, in_handler} !== {30'h40, 3'd1, 1'b0}) begin
               failures++;
               $display("FAIL eret_regs: epc=%h code=%0d inh=%b want 40/1/0", epc, exp_code, in_handler);
            end
         end
      end
      checks++;
      if ({epc, exp_code, in_handler} !== {30'h60, 3'd4, 1'b1}) begin
         failures++;
         $display("FAIL fault_wins_regs: epc=%h code=%0d inh=%b want 60/4/1", epc, exp_code, in_handler);
      end
      irq = 1'b0;
      drive(0, 0, 0, 1, 30'h64, 3'd7);
      tick();
   endtask

   task automatic test_eret_priv();
`ifdef PIPE_CTRL_PERF_EN
      ec_snap = exc_cnt;
`endif
      drive(0, 0, 0, 1, 30'h22, 3'd7);
      expect_ctl("eret_priv", 4'b0000, 4'b1111, 1'b1, 30'h10);
      #1;
      e = sb.pop_front(); checks++;
      if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
         failures++;
         $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                  e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
      end
      tick();
      checks++;
      if ({epc, exp_code, in_handler} !== {30'h22, 3'd6, 1'b1}) begin
         failures++;
         $display("FAIL eret_priv_regs: epc=%h code=%0d inh=%b want 22/6/1", epc, exp_code, in_handler);
      end
`ifdef PIPE_CTRL_PERF_EN
      checks++;
      if (exc_cnt !== ec_snap + 16'd1) begin
         failures++;
         $display("FAIL eret_priv_exc_cnt: got %0d want %0d", exc_cnt, ec_snap + 16'd1);
      end
`endif
   endtask

   task automatic test_double_fault();
      drive(0, 0, 0, 1, 30'h30, 3'd2);
      expect_ctl("double_fault", 4'b0000, 4'b1111, 1'b1, 30'h10);
      #1;
      e = sb.pop_front(); checks++;
      if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
         failures++;
         $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                  e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
      end
      tick();
      checks++;
      if ({halted, epc, exp_code} !== {1'b1, 30'h22, 3'd6}) begin
         failures++;
         $display("FAIL double_regs: halt=%b epc=%h code=%0d want 1/22/6", halted, epc, exp_code);
      end
`ifdef PIPE_CTRL_PERF_EN
      sc_snap = stall_cnt;
`endif
      for (int i = 0; i < 10; i++) begin
         irq    = 1'($urandom_range(0, 1));
         int_en = 1'b1;
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'b1, 30'($urandom), 3'($urandom_range(0, 7)));
         expect_ctl($sformatf("halt_cyc%0d", i), 4'b1111, 4'b0000, 1'b0, 30'h0);
         #1;
         e = sb.pop_front(); checks++;
         if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
            failures++;
            $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                     e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
         end
         tick();
      end
      checks++;
      if ({halted, epc} !== {1'b1, 30'h22}) begin
         failures++;
         $display("FAIL halt_hold: halt=%b epc=%h want 1/22", halted, epc);
      end
`ifdef PIPE_CTRL_PERF_EN
      checks++;
      if (stall_cnt !== sc_snap) begin
         failures++;
         $display("FAIL halt_stall_cnt: got %0d want %0d", stall_cnt, sc_snap);
      end
`endif
      irq = 1'b0;
      int_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      reset = 1'b0;
      #1;
      checks++;
      if ({halted, in_handler, epc, exp_code, st_v, bus.new_pc} !== {1'b0, 1'b0, 30'h0, 3'd0, 4'b1111, 30'h0}) begin
         failures++;
         $display("FAIL async_reset: halt=%b inh=%b epc=%h code=%0d stall=%b new_pc=%h",
                  halted, in_handler, epc, exp_code, st_v, bus.new_pc);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      drive(0, 0, 0, 1, 30'h77, 3'd5);
      expect_ctl("pre_reset_accept", 4'b0000, 4'b1111, 1'b1, 30'h10);
      #1;
      e = sb.pop_front(); checks++;
      if (st_v !== e.st || fl_v !== e.fl || (e.chk_pc && bus.new_pc !== e.pc)) begin
         failures++;
         $display("FAIL %s: stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                  e.tag, st_v, fl_v, bus.new_pc, e.st, e.fl, e.pc);
      end
      #2;
      reset = 1'b0;
      tick();
      checks++;
      if ({epc, exp_code, in_handler} !== {30'h0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid_exc: epc=%h code=%0d inh=%b want 0/0/0", epc, exp_code, in_handler);
      end
      drive(0, 0, 0, 0, 30'h0, 3'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_mem_busy();
      test_ld_hazard();
      test_irq();
      test_eret_priv();
      test_double_fault();
      test_reset_mid();
      checks++;
      if (sb.size() !== 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
